// File: rtl/diver_collision_detector_pkg.sv
// Shared game definitions for the diver collision detector slice.
// Contents:
//   MAX_X, MAX_Y : visible frame size; the last visible pixel is (MAX_X-1, MAX_Y-1)
//   state_t      : detector state encoding (PLAY, IMMUNE, OVER)
//   SPRITE_BG    : background colour shared with the display path
//   sat_inc8     : 8-bit saturating increment used by the overlap counter
package diver_collision_detector_pkg;

    localparam int unsigned MAX_X = 32'd640;
    localparam int unsigned MAX_Y = 32'd480;

    localparam logic [11:0] SPRITE_BG = 12'h6DE;

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        IMMUNE = 2'd1,
        OVER   = 2'd2
    } state_t;

    // Increment that sticks at 255 instead of wrapping to 0.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = 8'hFF;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/diver_collision_detector_if.sv
// Pixel-stream and status bundle of the diver collision detector.
// Signals:
//   p_tick, video_on, x, y    : timing and coordinate stream from vga_sync
//   diver_on, obstacle_on     : sprite pixel-valid flags aligned with x/y
//   collision                 : one-clk hit pulse towards diver_controller
//   immune, lives, game_over  : status towards display_top
// Modports:
//   master : pixel-stream source / status sink
//   slave  : the detector itself
interface diver_collision_detector_if;

    logic       p_tick;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic       diver_on;
    logic       obstacle_on;
    logic       collision;
    logic       immune;
    logic [1:0] lives;
    logic       game_over;

    modport master (
        output p_tick, video_on, x, y, diver_on, obstacle_on,
        input  collision, immune, lives, game_over
    );

    modport slave (
        input  p_tick, video_on, x, y, diver_on, obstacle_on,
        output collision, immune, lives, game_over
    );

endinterface

// File: rtl/diver_collision_detector_frame_overlap_counter.sv
// Counts, per frame, the visible pixels where diver and obstacle overlap, and
// flags the frame-end pixel together with the hit decision for that frame.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   p_tick, video_on, x, y   : pixel stream from vga_sync
//   diver_on, obstacle_on    : sprite pixel flags aligned with x/y
//   frame_end                : high on the p_tick cycle at (MAX_X-1, MAX_Y-1)
//   hit                      : high with frame_end when the frame reached OVERLAP_MIN
// frame_end and hit are decoded from the registered count plus the current
// pixel so the parent can register its decision on the very next edge, which
// keeps the outputs one clock behind the frame-end tick.
module diver_collision_detector_frame_overlap_counter
    import diver_collision_detector_pkg::*;
#(
    parameter int unsigned FRAME_W     = MAX_X,
    parameter int unsigned FRAME_H     = MAX_Y,
    parameter int unsigned OVERLAP_MIN = 32'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick,
    input  logic       video_on,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       diver_on,
    input  logic       obstacle_on,
    output logic       frame_end,
    output logic       hit
);

    localparam logic [9:0] X_LAST = 10'(FRAME_W - 32'd1);
    localparam logic [9:0] Y_LAST = 10'(FRAME_H - 32'd1);
    localparam logic [7:0] MIN_C  = 8'(OVERLAP_MIN);

    logic [7:0] overlap_cnt_r;
    logic [7:0] cnt_incl_s;
    logic       overlap_s;
    logic       frame_end_s;
    logic       hit_s;

    // Count including the current pixel, so an overlap on the frame-end pixel
    // still belongs to the frame it closes.
    always_comb begin
        overlap_s   = p_tick & video_on & diver_on & obstacle_on;
        if (overlap_s) begin
            cnt_incl_s = sat_inc8(overlap_cnt_r);
        end else begin
            cnt_incl_s = overlap_cnt_r;
        end
        frame_end_s = p_tick & (x == X_LAST) & (y == Y_LAST);
        hit_s       = frame_end_s & (cnt_incl_s >= MIN_C);
    end

    // Overlap accumulator; restarts at every frame end.
    always_ff @(posedge clk) begin
        if (reset) begin
            overlap_cnt_r <= 8'd0;
        end else if (frame_end_s) begin
            overlap_cnt_r <= 8'd0;
        end else begin
            overlap_cnt_r <= cnt_incl_s;
        end
    end

    assign frame_end = frame_end_s;
    assign hit       = hit_s;

endmodule

// File: rtl/diver_collision_detector.sv
// Pixel-overlap collision detector upstream of diver_controller. Decides on a
// hit at each frame end, pulses collision, and tracks lives, the immunity
// window after a hit, and game-over.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : diver_collision_detector_if.slave (pixel stream in, status out)
// All status outputs are registered and change one clock after the frame-end tick.
module diver_collision_detector
    import diver_collision_detector_pkg::*;
#(
    parameter int unsigned OVERLAP_MIN   = 32'd4,
    parameter int unsigned LIVES         = 32'd3,
    parameter int unsigned IMMUNE_FRAMES = 32'd120
) (
    input  logic                        clk,
    input  logic                        reset,
    diver_collision_detector_if.slave   bus
);

    localparam logic [1:0] LIVES_C  = 2'(LIVES);
    localparam logic [7:0] IMMUNE_C = 8'(IMMUNE_FRAMES);

    logic       frame_end_s;
    logic       hit_s;
    state_t     state_r;
    logic [7:0] imm_cnt_r;
    logic       collision_r;
    logic       immune_r;
    logic [1:0] lives_r;
    logic       game_over_r;

    diver_collision_detector_frame_overlap_counter #(
        .FRAME_W     (MAX_X),
        .FRAME_H     (MAX_Y),
        .OVERLAP_MIN (OVERLAP_MIN)
    ) u_counter (
        .clk         (clk),
        .reset       (reset),
        .p_tick      (bus.p_tick),
        .video_on    (bus.video_on),
        .x           (bus.x),
        .y           (bus.y),
        .diver_on    (bus.diver_on),
        .obstacle_on (bus.obstacle_on),
        .frame_end   (frame_end_s),
        .hit         (hit_s)
    );

    // Game FSM: acts only at frame end; collision is a single-clock pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= PLAY;
            imm_cnt_r   <= 8'd0;
            collision_r <= 1'b0;
            immune_r    <= 1'b0;
            lives_r     <= LIVES_C;
            game_over_r <= 1'b0;
        end else begin
            collision_r <= 1'b0;
            if (frame_end_s) begin
                case (state_r)
                    PLAY: begin
                        if (hit_s && (lives_r != 2'd0)) begin
                            collision_r <= 1'b1;
                            lives_r     <= lives_r - 2'd1;
                            imm_cnt_r   <= IMMUNE_C;
                            if (lives_r == 2'd1) begin
                                state_r     <= OVER;
                                game_over_r <= 1'b1;
                                immune_r    <= 1'b0;
                            end else begin
                                state_r  <= IMMUNE;
                                immune_r <= 1'b1;
                            end
                        end else begin
                            state_r <= PLAY;
                        end
                    end
                    IMMUNE: begin
                        // The frame on which immunity expires is still ignored.
                        if (imm_cnt_r <= 8'd1) begin
                            imm_cnt_r <= 8'd0;
                            state_r   <= PLAY;
                            immune_r  <= 1'b0;
                        end else begin
                            imm_cnt_r <= imm_cnt_r - 8'd1;
                        end
                    end
                    OVER: begin
                        state_r     <= OVER;
                        game_over_r <= 1'b1;
                        immune_r    <= 1'b0;
                    end
                    default: begin
                        // Unreachable encoding: fall back to the harmless game-over state.
                        state_r     <= OVER;
                        game_over_r <= 1'b1;
                        immune_r    <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign bus.collision = collision_r;
    assign bus.immune    = immune_r;
    assign bus.lives     = lives_r;
    assign bus.game_over = game_over_r;

endmodule

// File: tb/tb_diver_collision_detector.sv
module tb_diver_collision_detector;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    diver_collision_detector_if ifa ();
    diver_collision_detector_if ifb ();

    // Second instance (OVERLAP_MIN=1) sees the same pixel stream.
    assign ifb.p_tick      = ifa.p_tick;
    assign ifb.video_on    = ifa.video_on;
    assign ifb.x           = ifa.x;
    assign ifb.y           = ifa.y;
    assign ifb.diver_on    = ifa.diver_on;
    assign ifb.obstacle_on = ifa.obstacle_on;

    diver_collision_detector dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    diver_collision_detector #(.OVERLAP_MIN(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       pt;
        logic       vo;
        logic [9:0] px;
        logic [9:0] py;
        logic       d;
        logic       o;
        int         e_col;
        int         e_imm;
        int         e_lives;
        int         e_go;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int col, input int imm, input int lv, input int go);
        chk({tag, ".collision"}, int'(ifa.collision), col);
        chk({tag, ".immune"},    int'(ifa.immune),    imm);
        chk({tag, ".lives"},     int'(ifa.lives),     lv);
        chk({tag, ".game_over"}, int'(ifa.game_over), go);
    endtask

    task automatic pix(input logic pt, input logic vo, input logic [9:0] px,
                       input logic [9:0] py, input logic d, input logic o);
        @(negedge clk);
        ifa.p_tick      = pt;
        ifa.video_on    = vo;
        ifa.x           = px;
        ifa.y           = py;
        ifa.diver_on    = d;
        ifa.obstacle_on = o;
    endtask

    task automatic idle();
        pix(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset           = 1'b1;
        ifa.p_tick      = 1'b0;
        ifa.video_on    = 1'b0;
        ifa.x           = 10'd0;
        ifa.y           = 10'd0;
        ifa.diver_on    = 1'b0;
        ifa.obstacle_on = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // n overlapping visible pixels, then the frame-end pixel, then one idle
    // cycle; on return the outputs show the frame-end decision.
    task automatic frame(input int n_ov);
        for (int i = 0; i < n_ov; i++) begin
            pix(1'b1, 1'b1, 10'(100 + i), 10'd50, 1'b1, 1'b1);
        end
        pix(1'b1, 1'b1, 10'd639, 10'd479, 1'b0, 1'b0);
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        ifa.p_tick = 1'b0; ifa.video_on = 1'b0; ifa.x = 10'd0; ifa.y = 10'd0;
        ifa.diver_on = 1'b0; ifa.obstacle_on = 1'b0;

        //          pt    vo    x        y        d     o     col imm lv go
        vecs[0]  = '{1'b0, 1'b1, 10'd639, 10'd479, 1'b1, 1'b1, 0, 0, 3, 0};
        vecs[1]  = '{1'b1, 1'b1, 10'd20,  10'd10,  1'b1, 1'b1, 0, 0, 3, 0};
        vecs[2]  = '{1'b1, 1'b1, 10'd21,  10'd10,  1'b1, 1'b1, 0, 0, 3, 0};
        vecs[3]  = '{1'b1, 1'b1, 10'd22,  10'd10,  1'b1, 1'b0, 0, 0, 3, 0};
        vecs[4]  = '{1'b1, 1'b1, 10'd23,  10'd10,  1'b1, 1'b1, 0, 0, 3, 0};
        vecs[5]  = '{1'b1, 1'b0, 10'd645, 10'd10,  1'b1, 1'b1, 0, 0, 3, 0};
        vecs[6]  = '{1'b0, 1'b1, 10'd24,  10'd10,  1'b1, 1'b1, 0, 0, 3, 0};
        vecs[7]  = '{1'b1, 1'b1, 10'd639, 10'd479, 1'b0, 1'b0, 0, 0, 3, 0};
        vecs[8]  = '{1'b1, 1'b1, 10'd639, 10'd479, 1'b1, 1'b1, 0, 0, 3, 0};
        vecs[9]  = '{1'b1, 1'b1, 10'd30,  10'd20,  1'b1, 1'b1, 0, 0, 3, 0};
        vecs[10] = '{1'b1, 1'b1, 10'd31,  10'd20,  1'b1, 1'b1, 0, 0, 3, 0};
        vecs[11] = '{1'b1, 1'b1, 10'd32,  10'd20,  1'b1, 1'b1, 0, 0, 3, 0};
        vecs[12] = '{1'b1, 1'b1, 10'd639, 10'd479, 1'b1, 1'b1, 1, 1, 2, 0};
        vecs[13] = '{1'b0, 1'b0, 10'd0,   10'd0,   1'b0, 1'b0, 0, 1, 2, 0};
        vecs[14] = '{1'b1, 1'b1, 10'd639, 10'd479, 1'b1, 1'b1, 0, 1, 2, 0};

        // Reset state of both instances.
        do_reset();
        chk_a("reset", 0, 0, 3, 0);
        chk("reset.b_lives", int'(ifb.lives), 3);

        // Table: 3-overlap frame (no hit), cleared count, 4-overlap hit, immune frame.
        for (int i = 0; i < NV; i++) begin
            pix(vecs[i].pt, vecs[i].vo, vecs[i].px, vecs[i].py, vecs[i].d, vecs[i].o);
            if (i > 0) begin
                chk_a($sformatf("vec%0d", i - 1), vecs[i-1].e_col, vecs[i-1].e_imm,
                      vecs[i-1].e_lives, vecs[i-1].e_go);
            end
        end
        idle();
        chk_a($sformatf("vec%0d", NV - 1), vecs[NV-1].e_col, vecs[NV-1].e_imm,
              vecs[NV-1].e_lives, vecs[NV-1].e_go);

        // Immunity window: 120 overlapping frames ignored, then re-armed.
        do_reset();
        frame(4);
        chk_a("t3.hit", 1, 1, 2, 0);
        idle();
        chk("t3.pulse_width", int'(ifa.collision), 0);
        for (int k = 1; k <= 120; k++) begin
            frame(10);
            chk($sformatf("t3.col[%0d]", k), int'(ifa.collision), 0);
            chk($sformatf("t3.imm[%0d]", k), int'(ifa.immune), (k < 120) ? 1 : 0);
        end
        chk("t3.lives_kept", int'(ifa.lives), 2);
        frame(4);
        chk_a("t3.rearm", 1, 1, 1, 0);

        // Three spaced hits down to game over, then terminal.
        do_reset();
        frame(4);
        chk_a("t4.hit1", 1, 1, 2, 0);
        repeat (120) frame(0);
        chk("t4.imm_off1", int'(ifa.immune), 0);
        frame(4);
        chk_a("t4.hit2", 1, 1, 1, 0);
        repeat (120) frame(0);
        frame(4);
        chk_a("t4.hit3", 1, 0, 0, 1);
        idle();
        chk("t4.pulse_width", int'(ifa.collision), 0);
        for (int k = 0; k < 2; k++) begin
            frame(10);
            chk_a($sformatf("t4.over[%0d]", k), 0, 0, 0, 1);
        end

        // Overlap only on the frame-end pixel, OVERLAP_MIN=1 instance.
        do_reset();
        pix(1'b1, 1'b1, 10'd639, 10'd479, 1'b1, 1'b1);
        idle();
        chk("t5.b_col", int'(ifb.collision), 1);
        chk("t5.b_lives", int'(ifb.lives), 2);
        chk("t5.a_col", int'(ifa.collision), 0);
        do_reset();
        pix(1'b1, 1'b0, 10'd639, 10'd479, 1'b1, 1'b1);
        idle();
        chk("t5.novis_col", int'(ifb.collision), 0);
        chk("t5.novis_lives", int'(ifb.lives), 3);
        do_reset();
        repeat (3) pix(1'b0, 1'b1, 10'd639, 10'd479, 1'b1, 1'b1);
        idle();
        chk("t5.notick_col", int'(ifb.collision), 0);
        pix(1'b1, 1'b1, 10'd639, 10'd479, 1'b0, 1'b0);
        idle();
        chk("t5.notick_frame_col", int'(ifb.collision), 0);
        chk("t5.notick_frame_lives", int'(ifb.lives), 3);

        // Mid-frame reset discards the partial count.
        do_reset();
        frame(4);
        chk("t6.pre_lives", int'(ifa.lives), 2);
        repeat (3) pix(1'b1, 1'b1, 10'd200, 10'd60, 1'b1, 1'b1);
        do_reset();
        chk_a("t6.reset", 0, 0, 3, 0);
        pix(1'b1, 1'b1, 10'd201, 10'd60, 1'b1, 1'b1);
        pix(1'b1, 1'b1, 10'd639, 10'd479, 1'b0, 1'b0);
        idle();
        chk_a("t6.frame", 0, 0, 3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
